grf_wb_arbiter: RTL

Write-port controller for the single-write-port general register file. Shares that port between the main pipeline W stage and one long-latency auxiliary source (MDU / bus-load return). The auxiliary source uses a valid/ready handshake and a small FIFO; the pipeline W stage always has priority. Holds a 32-entry pending-write scoreboard so the hazard unit can stall readers of registers with outstanding auxiliary writes. Sits between the W stage / aux unit and the register file write port (A3/WD; A3 == 0 means no write).

---
 rtl/grf_wb_arbiter_pkg.sv | 12 +
 rtl/grf_wb_arbiter_wb_fifo.sv | 41 ++++
 rtl/grf_wb_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: register/data widths
// and the auxiliary result entry carried through the aux FIFO.
package grf_wb_arbiter_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
  } aux_entry_t;
endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding auxiliary write-back results until the
// register-file port is free. Caller never pushes when full nor pops when empty.
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  aux_entry_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output aux_entry_t head
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty after wrap.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  aux_entry_t  mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the single register-file write port between the W stage (priority)
// and a queued auxiliary source; tracks pending aux writes for hazard stalls.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  pipe_a3,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [REG_W-1:0]  aux_a3,
  input  logic [DATA_W-1:0] aux_wd,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_a3,
  input  logic [REG_W-1:0]  q_a1,
  input  logic [REG_W-1:0]  q_a2,
  output logic              q_stall,
  output logic              pipe_hold,
  output logic [REG_W-1:0]  grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic              sb_err
);
  localparam int NREG = 2 ** REG_W;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_LIMIT - 1);

  logic            fifo_full;
  logic            fifo_empty;
  aux_entry_t      head;
  logic            pipe_sel;
  logic            commit;
  logic            push_req;
  logic            push_ok;
  logic            bad_push;
  logic            iss_set;
  logic            iss_dup;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [CW-1:0]   starve_cnt;

  assign aux_ready = !fifo_full;
  assign push_req  = aux_valid && !fifo_full;
  assign push_ok   = push_req && (aux_a3 != REG_ZERO);
  assign bad_push  = push_req && (aux_a3 == REG_ZERO);
  assign pipe_sel  = (pipe_a3 != REG_ZERO);
  assign commit    = !pipe_sel && !fifo_empty;

  wb_fifo #(.DEPTH(AUX_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_ok),
    .push_data ({aux_a3, aux_wd}),
    .pop       (commit),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    grf_a3 = REG_ZERO;
    grf_wd = '0;
    if (pipe_sel) begin
      grf_a3 = pipe_a3;
      grf_wd = pipe_wd;
    end else if (!fifo_empty) begin
      grf_a3 = head.a3;
      grf_wd = head.wd;
    end
  end

  // Set and clear of the same register in one cycle resolves to set.
  assign iss_set = iss_valid && (iss_a3 != REG_ZERO);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_set) set_vec[iss_a3] = 1'b1;
    if (commit)  clr_vec[head.a3] = 1'b1;
  end

  assign iss_dup = iss_set && pending[iss_a3] && !clr_vec[iss_a3];
  assign q_stall = pending[q_a1] | pending[q_a2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      sb_err  <= sb_err | iss_dup | bad_push;
    end
  end

  // Starvation: a head blocked STARVE_LIMIT cycles in a row forces one bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else begin
      pipe_hold <= 1'b0;
      if (commit || fifo_empty) begin
        starve_cnt <= '0;
      end else if (starve_cnt == STARVE_LAST) begin
        starve_cnt <= '0;
        pipe_hold  <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
endmodule
